// File: rtl/as_pkg.sv
// Shared encodings for the add/sub accumulator front end.
package as_pkg;

   localparam int AS_WIDTH = 4;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/as_alu_comb.sv
// Combinational two's-complement add/sub step applied to the running accumulator.
module as_alu_comb
   import as_pkg::*;
#(
   parameter int WIDTH = AS_WIDTH
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   output logic [WIDTH-1:0] nxt_acc,
   output logic             carry,
   output logic             ovf,
   output logic             zero
);

   logic             is_sub;
   logic [WIDTH-1:0] bs;
   logic [WIDTH:0]   sum;

   // SUB is acc + ~b + 1, so carry-out reads as "no borrow"
   assign is_sub = (in_op == OP_SUB);
   assign bs     = is_sub ? ~in_data : in_data;
   assign sum    = {1'b0, acc} + {1'b0, bs} + {{WIDTH{1'b0}}, is_sub};

   always_comb begin
      nxt_acc = '0;
      carry   = 1'b0;
      ovf     = 1'b0;
      case (in_op)
         OP_LOAD: nxt_acc = in_data;
         OP_ADD, OP_SUB: begin
            nxt_acc = sum[WIDTH-1:0];
            carry   = sum[WIDTH];
            ovf     = (acc[WIDTH-1] == bs[WIDTH-1]) & (sum[WIDTH-1] != acc[WIDTH-1]);
         end
         default: nxt_acc = '0;
      endcase
   end

   assign zero = (nxt_acc == '0);

endmodule

// File: rtl/as_accumulator.sv
// Command-driven accumulator with a one-entry result register and valid/ready backpressure.
module as_accumulator
   import as_pkg::*;
#(
   parameter int WIDTH = AS_WIDTH,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_acc,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [CNT_W-1:0] out_cnt
);

   logic [0:0]       state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] nxt_acc;
   logic             nxt_carry, nxt_ovf, nxt_zero;
   logic             accept;

   as_alu_comb #(.WIDTH(WIDTH)) u_alu (
      .acc     (acc),
      .in_data (in_data),
      .in_op   (in_op),
      .nxt_acc (nxt_acc),
      .carry   (nxt_carry),
      .ovf     (nxt_ovf),
      .zero    (nxt_zero)
   );

   assign in_ready  = (state == ST_EMPTY) | out_ready;
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == ST_FULL);
   // acc only changes on accept, so it doubles as the result value
   assign out_acc   = acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_EMPTY;
         acc       <= '0;
         out_carry <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b1;
         out_cnt   <= '0;
      end else if (accept) begin
         state     <= ST_FULL;
         acc       <= nxt_acc;
         out_carry <= nxt_carry;
         out_ovf   <= nxt_ovf;
         out_zero  <= nxt_zero;
         out_cnt   <= out_cnt + 1'b1;
      end else if (state == ST_FULL && out_ready) begin
         state <= ST_EMPTY;
      end
   end

endmodule

// File: tb/tb_as_accumulator.sv
// Directed bench for as_accumulator with hand-computed expected results.
module tb_as_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_op;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_acc;
   logic       out_carry;
   logic       out_ovf;
   logic       out_zero;
   logic [7:0] out_cnt;

   int n_chk = 0;
   int n_err = 0;

   as_accumulator #(.WIDTH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_carry (out_carry),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .out_cnt   (out_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one accepted command followed by a full check of the result register
   task automatic cmd(input logic [1:0] op, input logic [3:0] d, input logic [3:0] e_acc,
                      input logic e_c, input logic e_v, input logic e_z, input logic [7:0] e_cnt);
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      chk("pre_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("valid", out_valid, 1);
      chk("acc",   out_acc,   e_acc);
      chk("carry", out_carry, e_c);
      chk("ovf",   out_ovf,   e_v);
      chk("zero",  out_zero,  e_z);
      chk("cnt",   out_cnt,   e_cnt);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = 4'h0; out_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_acc",   out_acc,   0);
      chk("rst_zero",  out_zero,  1);
      chk("rst_cnt",   out_cnt,   0);
      chk("rst_ready", in_ready,  1);

      // LOAD 5, ADD 3 (signed overflow into 8)
      cmd(2'b00, 4'd5, 4'd5, 0, 0, 0, 8'd1);
      cmd(2'b01, 4'd3, 4'd8, 0, 1, 0, 8'd2);

      // LOAD 8, SUB 9 -> 15 with borrow; ADD 1 wraps to 0; SUB 0 -> no borrow
      cmd(2'b00, 4'd8, 4'd8,  0, 0, 0, 8'd3);
      cmd(2'b10, 4'd9, 4'd15, 0, 0, 0, 8'd4);
      cmd(2'b01, 4'd1, 4'd0,  1, 0, 1, 8'd5);
      cmd(2'b10, 4'd0, 4'd0,  1, 0, 1, 8'd6);

      // back-to-back: cmd() drops in_valid only after the edge, so these are consecutive accepts
      cmd(2'b00, 4'd1, 4'd1, 0, 0, 0, 8'd7);
      cmd(2'b01, 4'd2, 4'd3, 0, 0, 0, 8'd8);
      cmd(2'b01, 4'd3, 4'd6, 0, 0, 0, 8'd9);
      cmd(2'b10, 4'd1, 4'd5, 1, 0, 0, 8'd10);

      // stall while FULL
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 2'b01; in_data = 4'd4;
      #1;
      chk("stall_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_ready", in_ready,  0);
         chk("stall_valid", out_valid, 1);
         chk("stall_acc",   out_acc,   5);
         chk("stall_cnt",   out_cnt,   10);
         chk("stall_carry", out_carry, 1);
      end
      // release: drain and accept on the same edge, 5+4 overflows signed
      out_ready = 1'b1;
      #1;
      chk("rel_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("rel_valid", out_valid, 1);
      chk("rel_acc",   out_acc,   9);
      chk("rel_ovf",   out_ovf,   1);
      chk("rel_carry", out_carry, 0);
      chk("rel_cnt",   out_cnt,   11);

      // drain without accept
      step();
      chk("drain_valid", out_valid, 0);
      chk("drain_acc",   out_acc,   9);
      chk("drain_cnt",   out_cnt,   11);

      // reset mid-operation with a stalled command pending
      cmd(2'b00, 4'd3, 4'd3, 0, 0, 0, 8'd12);
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 2'b01; in_data = 4'd2;
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_acc",   out_acc,   0);
      chk("mrst_zero",  out_zero,  1);
      chk("mrst_cnt",   out_cnt,   0);

      // counter wrap after 256 CLRs
      in_valid = 1'b1; in_op = 2'b11; in_data = 4'hA;
      for (int i = 0; i < 255; i++) step();
      chk("wrap_255", out_cnt, 255);
      step();
      in_valid = 1'b0;
      chk("wrap_0",    out_cnt,  0);
      chk("wrap_acc",  out_acc,  0);
      chk("wrap_zero", out_zero, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/as_accumulator.md
Name: as_accumulator

Overview:
- Sequential front end that feeds the team's 4-bit parallel add/sub datapath.
- Accepts a stream of commands over a valid/ready handshake: LOAD, ADD, SUB, CLR.
- Keeps a running accumulator and applies each command to it with two's-complement add/subtract.
- Presents each result with carry, overflow and zero flags through a one-entry output register with backpressure.

Parameters:
- WIDTH, 4, datapath and accumulator width in bits (min 2).
- CNT_W, 8, width of the accepted-command counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  block can accept a command this cycle.
- in_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- in_data  input  WIDTH  operand; ignored for CLR.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_acc  output  WIDTH  accumulator value after the command.
- out_carry  output  1  adder carry-out: ADD = unsigned carry, SUB = no-borrow.
- out_ovf  output  1  signed two's-complement overflow.
- out_zero  output  1  out_acc == 0.
- out_cnt  output  CNT_W  number of accepted commands, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at an edge):
  - acc, out_acc, out_carry, out_ovf and out_cnt clear to 0; out_zero = 1; out_valid = 0; FSM goes to EMPTY.
  - rst overrides any handshake in the same cycle; a pending result is discarded.
- FSM states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - in_ready = (state==EMPTY) | out_ready. It is combinational and does not depend on in_valid.
- Accept: in_valid & in_ready at an edge.
  - acc and the result register update on that same edge; out_cnt increments.
  - Next state is FULL. Latency is 1 cycle from accept to out_valid.
- Drain without accept: FULL & out_ready & ~accept -> EMPTY. Result fields hold their last value.
- Simultaneous drain + accept in FULL: old result is consumed, new result loads on the same edge, state stays FULL. Full throughput is 1 command per cycle.
- Stall: FULL & ~out_ready -> in_ready=0; acc and all out_* hold their values.
- Arithmetic, with bs = SUB ? ~in_data : in_data, cin = SUB, and {c, s} = acc + bs + cin at WIDTH+1 bits:
  - LOAD: acc <= in_data; carry=0; ovf=0.
  - ADD / SUB: acc <= s; carry = c; ovf = (acc[MSB]==bs[MSB]) & (s[MSB]!=acc[MSB]).
  - CLR: acc <= 0; carry=0; ovf=0.
  - zero is computed from the new acc value for every op.
- Wrap-around: the accumulator wraps modulo 2^WIDTH with no saturation. out_cnt wraps from 2^CNT_W-1 to 0.
- Command while EMPTY with out_ready=1: accepted normally; out_ready has no effect while EMPTY.

Decomposition:
- Shared package as_pkg holds:
  - op encodings OP_LOAD, OP_ADD, OP_SUB, OP_CLR;
  - FSM state encodings ST_EMPTY, ST_FULL;
  - default WIDTH.
- One sub-module, as_alu_comb (combinational). Inputs: acc, in_data, in_op. Outputs: next acc, carry, ovf, zero.
- as_accumulator holds the acc, FSM, result and counter registers, plus the handshake logic.

Test Plan (WIDTH=4, out_ready=1 unless stated):
- Reset: rst=1 for 2 cycles -> out_valid=0, out_acc=0, out_zero=1, out_cnt=0, in_ready=1.
- LOAD 5 then ADD 3 -> results 5 (c0 v0 z0), then 8 (c0 v1 z0). out_cnt=2; each result appears 1 cycle after accept.
- Sequence:
  - LOAD 8, SUB 9 -> result 15 (c0 v0 z0).
  - ADD 1 -> result 0 (c1 v0 z1).
  - SUB 0 -> result 0 (c1 v0 z1).
- Back-to-back: 4 commands on consecutive cycles with out_ready=1 -> in_ready stays 1, out_valid stays 1, results appear on consecutive cycles.
- Backpressure:
  - Stall: FULL with out_ready=0 and in_valid=1 for 3 cycles -> in_ready=0 and acc/out_* stable.
  - Release: raise out_ready -> the pending command is accepted on the same edge as the drain.
- Reset mid-operation: rst=1 while FULL with stalled input -> next cycle out_valid=0, acc=0, out_cnt=0. After 2^CNT_W accepted CLRs, out_cnt wraps to 0.
